// File: rtl/mem_port_arbiter_pkg.sv
// arb_pkg: shared state encoding and defaults for the memory port arbiter
package arb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_DM = 2'd2
   } arb_state_e;
   localparam int MAX_DM_BURST_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake bundle around the arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              busy;
   logic              pipe_stall;
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
             busy, pipe_stall
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
             busy, pipe_stall
   );
endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating count of consecutive DM grants taken while IF waits
module arb_starve_cnt import arb_pkg::*; #(
   parameter int MAX = MAX_DM_BURST_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic dm_grant_i,
   input  logic if_grant_i,
   input  logic if_pending_i,
   output logic limit_hit_o
);
   localparam int W = $clog2(MAX + 1);
   logic [W-1:0] streak_q, streak_d;
   assign limit_hit_o = (streak_q == W'(MAX));
   always_comb begin
      streak_d = (if_grant_i || (dm_grant_i && !if_pending_i)) ? '0 :
                 (dm_grant_i && !limit_hit_o) ? streak_q + W'(1) : streak_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) streak_q <= '0;
      else     streak_q <= streak_d;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access, DM first
// with a bounded number of DM grants while IF waits
module mem_port_arbiter import arb_pkg::*; #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_DM_BURST = MAX_DM_BURST_DEF
) (
   input logic clk,
   input logic rst,
   mem_port_arbiter_if.slave bus
);
   arb_state_e        state_q, state_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic              if_elig, dm_elig, if_gnt, dm_gnt, limit_hit, done;
   // a requester in its ack cycle still holds req, so it must not be re-granted
   assign if_elig = bus.if_req & ~if_ack_q;
   assign dm_elig = bus.dm_req & ~dm_ack_q;
   assign if_gnt  = (state_q == IDLE) & if_elig & (~dm_elig | limit_hit);
   assign dm_gnt  = (state_q == IDLE) & dm_elig & ~if_gnt;
   assign done    = (state_q != IDLE) & bus.mem_ack;
   arb_starve_cnt #(.MAX(MAX_DM_BURST)) u_starve (
      .clk          (clk),
      .rst          (rst),
      .dm_grant_i   (dm_gnt),
      .if_grant_i   (if_gnt),
      .if_pending_i (if_elig),
      .limit_hit_o  (limit_hit)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = if_gnt ? GNT_IF : dm_gnt ? GNT_DM : IDLE;
         default: state_d = bus.mem_ack ? IDLE : state_q;
      endcase
   end
   always_comb begin
      mem_req_d   = (if_gnt | dm_gnt) ? 1'b1 : done ? 1'b0 : mem_req_q;
      mem_we_d    = dm_gnt ? bus.dm_we : if_gnt ? 1'b0 : mem_we_q;
      mem_addr_d  = dm_gnt ? bus.dm_addr : if_gnt ? bus.if_addr : mem_addr_q;
      mem_wdata_d = dm_gnt ? bus.dm_wdata : if_gnt ? '0 : mem_wdata_q;
      if_ack_d    = done & (state_q == GNT_IF);
      dm_ack_d    = done & (state_q == GNT_DM);
      if_rdata_d  = if_ack_d ? bus.mem_rdata : if_rdata_q;
      dm_rdata_d  = (dm_ack_d & ~mem_we_q) ? bus.mem_rdata : dm_rdata_q;
   end
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.if_ack     = if_ack_q;
   assign bus.dm_ack     = dm_ack_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.dm_rdata   = dm_rdata_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.pipe_stall = if_elig | dm_elig;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, handshakes, starvation limit and reset
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   mem_auto = 1'b0;
   int   mlat = 1;
   int   mcnt = 0;
   always #5 clk = ~clk;
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   // one cycle: wait for the falling edge, then let the memory model respond
   task step();
      @(negedge clk);
      if (mem_auto) begin
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            mcnt = 0;
         end else if (bus.mem_req) begin
            mcnt++;
            if (mcnt >= mlat) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = (bus.mem_addr == 32'h100) ? 32'h13 : ~bus.mem_addr;
            end
         end
      end
   endtask
   task test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ack, bus.dm_ack,
           bus.if_rdata, bus.dm_rdata, bus.busy, bus.pipe_stall} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got req=%0b we=%0b addr=%h busy=%0b", bus.mem_req, bus.mem_we, bus.mem_addr, bus.busy);
      end
      rst = 1'b0;
      step();
   endtask
   task test_if_read();
      int n;
      mem_auto = 1'b1; mlat = 3; mcnt = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      #1;
      checks++;
      if (bus.pipe_stall !== 1'b1) begin failures++; $display("FAIL if_stall_early got=%0b exp=1", bus.pipe_stall); end
      checks++;
      if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL if_req_latency got=%0b exp=0", bus.mem_req); end
      step();
      n = 1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.busy} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
         failures++;
         $display("FAIL if_grant got req=%0b we=%0b addr=%h busy=%0b exp 1 0 00000100 1", bus.mem_req, bus.mem_we, bus.mem_addr, bus.busy);
      end
      while (!bus.if_ack && n < 12) begin
         step();
         n++;
         if (!bus.if_ack) begin
            checks++;
            if ({bus.mem_req, bus.pipe_stall} !== 2'b11) begin
               failures++;
               $display("FAIL if_hold got req=%0b stall=%0b exp 1 1", bus.mem_req, bus.pipe_stall);
            end
         end
      end
      checks++;
      if (n !== 4) begin failures++; $display("FAIL if_latency got=%0d exp=4", n); end
      checks++;
      if ({bus.if_rdata, bus.pipe_stall, bus.mem_req} !== {32'h13, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL if_ack_cycle got rdata=%h stall=%0b req=%0b exp 00000013 0 0", bus.if_rdata, bus.pipe_stall, bus.mem_req);
      end
      bus.if_req = 1'b0;
      step();
      checks++;
      if ({bus.if_ack, bus.busy} !== 2'b00) begin failures++; $display("FAIL if_ack_pulse got ack=%0b busy=%0b exp 0 0", bus.if_ack, bus.busy); end
   endtask
   task test_dm_store();
      mlat = 1;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h3000; bus.dm_wdata = 32'h0;
      step();
      checks++;
      if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h3000}) begin failures++; $display("FAIL dm_load_grant got we=%0b addr=%h", bus.mem_we, bus.mem_addr); end
      step();
      checks++;
      if ({bus.dm_ack, bus.dm_rdata} !== {1'b1, 32'hFFFF_CFFF}) begin
         failures++;
         $display("FAIL dm_load_data got ack=%0b rdata=%h exp 1 ffffcfff", bus.dm_ack, bus.dm_rdata);
      end
      bus.dm_req = 1'b0;
      step();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEAD_BEEF;
      step();
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL dm_store_grant got req=%0b we=%0b addr=%h wdata=%h", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      step();
      checks++;
      if ({bus.dm_ack, bus.dm_rdata} !== {1'b1, 32'hFFFF_CFFF}) begin
         failures++;
         $display("FAIL dm_store_ack got ack=%0b rdata=%h exp 1 ffffcfff", bus.dm_ack, bus.dm_rdata);
      end
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      step();
      checks++;
      if (bus.dm_ack !== 1'b0) begin failures++; $display("FAIL dm_ack_pulse got=%0b exp=0", bus.dm_ack); end
   endtask
   task test_back_to_back();
      mlat = 1;
      bus.if_req = 1'b1; bus.if_addr = 32'h104;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2004;
      step();
      checks++;
      if (bus.mem_addr !== 32'h2004) begin failures++; $display("FAIL b2b_first got=%h exp=00002004", bus.mem_addr); end
      step();
      checks++;
      if ({bus.dm_ack, bus.if_ack} !== 2'b10) begin failures++; $display("FAIL b2b_dm_ack got dm=%0b if=%0b exp 1 0", bus.dm_ack, bus.if_ack); end
      bus.dm_req = 1'b0;
      step();
      checks++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h104}) begin
         failures++;
         $display("FAIL b2b_second got req=%0b addr=%h exp 1 00000104", bus.mem_req, bus.mem_addr);
      end
      step();
      checks++;
      if ({bus.if_ack, bus.dm_ack, bus.if_rdata} !== {1'b1, 1'b0, 32'hFFFF_FEFB}) begin
         failures++;
         $display("FAIL b2b_if_ack got if=%0b dm=%0b rdata=%h exp 1 0 fffffefb", bus.if_ack, bus.dm_ack, bus.if_rdata);
      end
      bus.if_req = 1'b0;
      step();
   endtask
   task test_starvation();
      logic [31:0] g [6];
      logic [31:0] exp_g [6];
      int ng, cyc;
      bit prev, if_done;
      exp_g = '{32'h2100, 32'h2100, 32'h2100, 32'h2100, 32'h108, 32'h2100};
      for (int i = 0; i < 6; i++) g[i] = '0;
      ng = 0; cyc = 0; prev = 1'b0; if_done = 1'b0; mlat = 1;
      bus.if_req = 1'b1; bus.if_addr = 32'h108;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2100;
      // IF steps aside in each dm_ack cycle so the DM streak can build up
      while (ng < 6 && cyc < 60) begin
         step();
         cyc++;
         if (bus.mem_req && !prev) begin
            g[ng] = bus.mem_addr;
            ng++;
            if (ng == 4) begin
               checks++;
               if (dut.u_starve.streak_q !== 3'd4) begin failures++; $display("FAIL starve_limit got=%0d exp=4", dut.u_starve.streak_q); end
            end
            if (bus.mem_addr == 32'h108) begin
               checks++;
               if (dut.u_starve.streak_q !== 3'd0) begin failures++; $display("FAIL starve_clear got=%0d exp=0", dut.u_starve.streak_q); end
            end
         end
         prev = bus.mem_req;
         if (bus.if_ack) if_done = 1'b1;
         bus.if_req = !if_done && !bus.dm_ack;
      end
      checks++;
      if (ng !== 6) begin failures++; $display("FAIL starve_grants got=%0d exp=6", ng); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (g[i] !== exp_g[i]) begin failures++; $display("FAIL starve_seq%0d got=%h exp=%h", i, g[i], exp_g[i]); end
      end
      bus.dm_req = 1'b0; bus.if_req = 1'b0;
      repeat (3) step();
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL starve_idle got=%0b exp=0", bus.busy); end
   endtask
   task test_async_reset();
      int n;
      mem_auto = 1'b0; bus.mem_ack = 1'b0;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2200;
      step();
      checks++;
      if ({bus.mem_req, bus.busy} !== 2'b11) begin failures++; $display("FAIL rst_pre got req=%0b busy=%0b exp 1 1", bus.mem_req, bus.busy); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.if_ack, bus.dm_ack,
           bus.if_rdata, bus.dm_rdata} !== '0) begin
         failures++;
         $display("FAIL rst_async got req=%0b addr=%h busy=%0b dm_rdata=%h if_rdata=%h", bus.mem_req, bus.mem_addr, bus.busy, bus.dm_rdata, bus.if_rdata);
      end
      bus.dm_req = 1'b0;
      step();
      rst = 1'b0;
      step();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
      step();
      bus.mem_ack = 1'b0;
      checks++;
      if ({bus.dm_ack, bus.if_ack, bus.busy, bus.mem_req, bus.dm_rdata} !== '0) begin
         failures++;
         $display("FAIL rst_late_ack got dm=%0b if=%0b busy=%0b req=%0b", bus.dm_ack, bus.if_ack, bus.busy, bus.mem_req);
      end
      mem_auto = 1'b1; mlat = 2; mcnt = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      n = 0;
      while (!bus.if_ack && n < 12) begin
         step();
         n++;
      end
      checks++;
      if ({n, bus.if_rdata} !== {32'd3, 32'h13}) begin
         failures++;
         $display("FAIL rst_recover got cycles=%0d rdata=%h exp 3 00000013", n, bus.if_rdata);
      end
      bus.if_req = 1'b0;
      step();
   endtask
   task test_stray_ack();
      mem_auto = 1'b0;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555;
      step();
      bus.mem_ack = 1'b0;
      checks++;
      if ({bus.busy, bus.if_ack, bus.dm_ack, bus.mem_req, bus.if_rdata} !== {4'b0, 32'h13}) begin
         failures++;
         $display("FAIL stray_ack got busy=%0b if=%0b dm=%0b req=%0b rdata=%h", bus.busy, bus.if_ack, bus.dm_ack, bus.mem_req, bus.if_rdata);
      end
      step();
      checks++;
      if ({bus.busy, bus.if_ack, bus.dm_ack} !== 3'b0) begin failures++; $display("FAIL stray_after got busy=%0b if=%0b dm=%0b", bus.busy, bus.if_ack, bus.dm_ack); end
   endtask
   initial begin
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ack = 1'b0;
      test_reset();
      test_if_read();
      test_dm_store();
      test_back_to_back();
      test_starvation();
      test_async_reset();
      test_stray_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
endmodule
